// File: rtl/counter_integrity_monitor_pkg.sv
// Shared definitions for the counter integrity monitor.
//   - cimState_t      : monitor FSM states (SYNC / TRACK / ALARM)
//   - ERR_* indices   : bit positions inside the sticky err_code vector
//   - DEFAULT_*       : count width and pulse period shared with the counter host
package counter_integrity_monitor_pkg;

    localparam int DEFAULT_COUNT_WIDTH = 12;
    localparam int DEFAULT_PERIOD      = 100;

    localparam int ERR_CODE_WIDTH = 3;
    localparam int ERR_SEQ        = 0;
    localparam int ERR_PERIOD     = 1;
    localparam int ERR_OVF        = 2;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        ALARM = 2'd2
    } cimState_t;

endpackage

// File: rtl/counter_integrity_monitor_predictor.sv
// Stream predictor for the counter integrity monitor.
// Keeps the delayed enable, the previous count sample and the last pulse
// reference, and flags which checks fail on the current sample.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_enable          : host enable (count advances two samples later)
//   i_count_in        : host count stream
//   i_overflow_in     : host overflow flag
//   i_pulse_in        : host period pulse
//   i_check_en        : high while the monitor is tracking (not in SYNC)
//   i_clear           : synchronous clear of the pulse reference valid flag
//   o_seq_fail        : count did not advance by the delayed enable
//   o_period_fail     : pulse arrived at the wrong distance from the last one
//   o_ovf_fail        : overflow rose while count was not all-ones
module cim_stream_predictor
    import counter_integrity_monitor_pkg::*;
#(
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
    parameter int PERIOD      = DEFAULT_PERIOD
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_enable,
    input  logic [COUNT_WIDTH-1:0] i_count_in,
    input  logic                   i_overflow_in,
    input  logic                   i_pulse_in,
    input  logic                   i_check_en,
    input  logic                   i_clear,
    output logic                   o_seq_fail,
    output logic                   o_period_fail,
    output logic                   o_ovf_fail
);

    localparam logic [COUNT_WIDTH-1:0] PERIOD_VAL = COUNT_WIDTH'(PERIOD);

    logic                   r_enD1;
    logic                   r_enD2;
    logic [COUNT_WIDTH-1:0] r_prevCount;
    logic [COUNT_WIDTH-1:0] r_pulseRef;
    logic                   r_pulseRefVld;
    logic                   r_pulseD1;
    logic                   r_ovfD1;

    logic [COUNT_WIDTH-1:0] w_expected;
    logic [COUNT_WIDTH-1:0] w_pulseDelta;
    logic                   w_pulseRise;
    logic                   w_ovfRise;

    // History registers follow the stream every cycle, mismatches included,
    // so one corrupted sample is seen both entering and leaving.
    // The pulse reference is only recorded while tracking; clear or SYNC
    // drops its valid flag so the next pulse merely records a new reference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enD1        <= 1'b0;
            r_enD2        <= 1'b0;
            r_prevCount   <= '0;
            r_pulseRef    <= '0;
            r_pulseRefVld <= 1'b0;
            r_pulseD1     <= 1'b0;
            r_ovfD1       <= 1'b0;
        end else begin
            r_enD1      <= i_enable;
            r_enD2      <= r_enD1;
            r_prevCount <= i_count_in;
            r_pulseD1   <= i_pulse_in;
            r_ovfD1     <= i_overflow_in;
            if (i_clear || !i_check_en) begin
                r_pulseRefVld <= 1'b0;
            end else if (w_pulseRise) begin
                r_pulseRef    <= i_count_in;
                r_pulseRefVld <= 1'b1;
            end
        end
    end

    // Per-sample predictions; all differences wrap modulo the count width,
    // so the all-ones to zero rollover is a legal advance.
    always_comb begin
        w_expected    = r_prevCount + {{(COUNT_WIDTH-1){1'b0}}, r_enD2};
        w_pulseDelta  = i_count_in - r_pulseRef;
        w_pulseRise   = i_pulse_in & ~r_pulseD1;
        w_ovfRise     = i_overflow_in & ~r_ovfD1;
        o_seq_fail    = i_check_en && (i_count_in != w_expected);
        o_period_fail = i_check_en && w_pulseRise && r_pulseRefVld
                        && (w_pulseDelta != PERIOD_VAL);
        o_ovf_fail    = i_check_en && w_ovfRise && (i_count_in != '1);
    end

endmodule

// File: rtl/counter_integrity_monitor.sv
// Receive-side integrity monitor for the counter host output stream.
// Predicts the host stream from its enable and raises a sticky tamper alarm
// with diagnostics when the observed stream deviates.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_enable          : enable driving the host counter
//   i_count_in        : host count_out
//   i_overflow_in     : host overflow
//   i_pulse_in        : host pulse_out
//   i_clear           : synchronous clear of alarm and diagnostics (back to SYNC)
//   o_tamper          : sticky alarm, high while in ALARM
//   o_err_code        : sticky causes [0] sequence, [1] period, [2] overflow
//   o_mismatch_cnt    : saturating count of cycles with any failing check
//   o_first_bad       : count sample captured at the first mismatch
module counter_integrity_monitor
    import counter_integrity_monitor_pkg::*;
#(
    parameter int COUNT_WIDTH   = DEFAULT_COUNT_WIDTH,
    parameter int PERIOD        = DEFAULT_PERIOD,
    parameter int ERR_CNT_WIDTH = 8,
    parameter int ALARM_THRESH  = 1
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_enable,
    input  logic [COUNT_WIDTH-1:0]    i_count_in,
    input  logic                      i_overflow_in,
    input  logic                      i_pulse_in,
    input  logic                      i_clear,
    output logic                      o_tamper,
    output logic [ERR_CODE_WIDTH-1:0] o_err_code,
    output logic [ERR_CNT_WIDTH-1:0]  o_mismatch_cnt,
    output logic [COUNT_WIDTH-1:0]    o_first_bad
);

    localparam logic [ERR_CNT_WIDTH-1:0] THRESH_VAL = ERR_CNT_WIDTH'(ALARM_THRESH);
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE    = ERR_CNT_WIDTH'(1);

    cimState_t                  r_state;
    cimState_t                  w_nextState;
    logic                       r_syncCnt;
    logic                       r_tamper;
    logic [ERR_CODE_WIDTH-1:0]  r_errCode;
    logic [ERR_CNT_WIDTH-1:0]   r_mismatchCnt;
    logic [COUNT_WIDTH-1:0]     r_firstBad;

    logic                       w_checkEn;
    logic                       w_tamperNext;
    logic                       w_seqFail;
    logic                       w_periodFail;
    logic                       w_ovfFail;
    logic [ERR_CODE_WIDTH-1:0]  w_failBits;
    logic                       w_anyFail;
    logic [ERR_CNT_WIDTH-1:0]   w_cntInc;

    cim_stream_predictor #(
        .COUNT_WIDTH (COUNT_WIDTH),
        .PERIOD      (PERIOD)
    ) u_predictor (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_enable      (i_enable),
        .i_count_in    (i_count_in),
        .i_overflow_in (i_overflow_in),
        .i_pulse_in    (i_pulse_in),
        .i_check_en    (w_checkEn),
        .i_clear       (i_clear),
        .o_seq_fail    (w_seqFail),
        .o_period_fail (w_periodFail),
        .o_ovf_fail    (w_ovfFail)
    );

    // Collect the failing checks of this sample and the saturated next count.
    always_comb begin
        w_failBits             = '0;
        w_failBits[ERR_SEQ]    = w_seqFail;
        w_failBits[ERR_PERIOD] = w_periodFail;
        w_failBits[ERR_OVF]    = w_ovfFail;
        w_anyFail              = |w_failBits;
        w_cntInc               = (r_mismatchCnt == '1) ? r_mismatchCnt
                                                       : r_mismatchCnt + CNT_ONE;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next state: SYNC lasts two cycles to fill the history registers,
    // TRACK escalates on the cycle the mismatch count reaches the threshold,
    // ALARM is left only through clear or reset.
    always_comb begin
        w_nextState = r_state;
        if (i_clear) begin
            w_nextState = SYNC;
        end else begin
            case (r_state)
                SYNC:    if (r_syncCnt) w_nextState = TRACK;
                TRACK:   if (w_anyFail && (w_cntInc >= THRESH_VAL)) w_nextState = ALARM;
                ALARM:   w_nextState = ALARM;
                default: w_nextState = SYNC;
            endcase
        end
    end

    // FSM outputs: checks run outside SYNC; tamper is registered from the
    // next state so it rises together with the mismatch count.
    always_comb begin
        w_checkEn    = (r_state != SYNC);
        w_tamperNext = (w_nextState == ALARM);
    end

    // SYNC cycle counter and registered tamper flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_syncCnt <= 1'b0;
            r_tamper  <= 1'b0;
        end else begin
            r_syncCnt <= (!i_clear && r_state == SYNC) ? 1'b1 : 1'b0;
            r_tamper  <= w_tamperNext;
        end
    end

    // Sticky diagnostics; clear wins over a failing sample in the same cycle.
    // first_bad is only captured while the mismatch count is still zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errCode     <= '0;
            r_mismatchCnt <= '0;
            r_firstBad    <= '0;
        end else if (i_clear) begin
            r_errCode     <= '0;
            r_mismatchCnt <= '0;
            r_firstBad    <= '0;
        end else if (w_anyFail) begin
            r_errCode     <= r_errCode | w_failBits;
            r_mismatchCnt <= w_cntInc;
            if (r_mismatchCnt == '0) begin
                r_firstBad <= i_count_in;
            end
        end
    end

    assign o_tamper       = r_tamper;
    assign o_err_code     = r_errCode;
    assign o_mismatch_cnt = r_mismatchCnt;
    assign o_first_bad    = r_firstBad;

endmodule
